// File: rtl/pdm_dac_pkg.sv
// ---------------------------------------------------------------------------
// pdm_dac_pkg : shared state encoding, width constants and saturation helper
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pdm_dac_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam int NCH_DEF      = 2;
    localparam int DW_DEF       = 16;
    localparam int OSR_LOG2_DEF = 8;

    // Interpolator accumulator: sign + DW integer bits + OSR_LOG2 fraction bits
    function automatic int acc_width(input int dw, input int osr_log2);
        return dw + osr_log2 + 1;
    endfunction

    localparam int ACC_W = acc_width(DW_DEF, OSR_LOG2_DEF);

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_sd_mod.sv
// ---------------------------------------------------------------------------
// pdm_sd_mod : one-channel sigma-delta modulator, first order by default,
//              second-order error feedback when PDM_DAC_ORDER2_EN is defined.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_sd_mod #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] sample,
    output logic                 pdm
);

`ifdef PDM_DAC_ORDER2_EN
    localparam int IW = DW + 3;
    localparam logic signed [IW:0] LIM = {2'b00, 1'b1, {(DW+1){1'b0}}};
    localparam logic signed [IW:0] FB  = {4'b0000, 1'b1, {(DW-1){1'b0}}};

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic                 q;
    logic signed [IW:0]   fb;
    logic signed [IW:0]   x;
    logic signed [IW:0]   i1n;
    logic signed [IW:0]   i2n;

    function automatic logic signed [IW:0] clamp(input logic signed [IW:0] v);
        if (v > LIM)  return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    // Sums are one bit wider than the integrators so clamping sees the true value
    always_comb begin
        fb  = q ? FB : -FB;
        x   = {{4{sample[DW-1]}}, sample};
        i1n = clamp($signed({i1[IW-1], i1}) + x - fb);
        i2n = clamp($signed({i2[IW-1], i2}) + i1n - fb);
    end

    // q always equals ~i2[MSB] of the registered integrator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1 <= '0;
            i2 <= '0;
            q  <= 1'b0;
        end else begin
            i1 <= i1n[IW-1:0];
            i2 <= i2n[IW-1:0];
            q  <= ~i2n[IW];
        end
    end

    assign pdm = q;
`else
    logic [DW-1:0] u;
    logic [DW:0]   sd;

    assign u = {~sample[DW-1], sample[DW-2:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd <= '0;
        end else begin
            sd <= {1'b0, sd[DW-1:0]} + {1'b0, u};
        end
    end

    assign pdm = sd[DW];
`endif

endmodule

`default_nettype wire

// File: rtl/pdm_dac_mc.sv
// ---------------------------------------------------------------------------
// pdm_dac_mc : multi-channel interpolating PDM DAC (modulator order selected
//              by PDM_DAC_ORDER2_EN inside pdm_sd_mod).
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_dac_mc
    import pdm_dac_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int DW       = DW_DEF,
    parameter int OSR_LOG2 = OSR_LOG2_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [NCH*DW-1:0] din,
    input  logic              ovr_clr,
    output logic              busy,
    output logic              ovr,
    output logic [NCH-1:0]    pdm
);

    localparam int AW = acc_width(DW, OSR_LOG2);
    localparam logic [OSR_LOG2-1:0] CNT_MAX = '1;

    state_t                state;
    logic [OSR_LOG2-1:0]   cnt;
    logic signed [AW-1:0]  acc    [NCH];
    logic signed [AW-1:0]  step   [NCH];
    logic signed [DW-1:0]  tgt    [NCH];
    logic signed [DW-1:0]  sample [NCH];

    function automatic logic signed [AW-1:0] to_acc(input logic signed [DW-1:0] v);
        return {v[DW-1], v, {OSR_LOG2{1'b0}}};
    endfunction

    // A load during a ramp holds acc for that cycle, so the restart is seamless
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            ovr   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc[k]  <= '0;
                step[k] <= '0;
                tgt[k]  <= '0;
            end
        end else begin
            if (load) begin
                state <= RAMP;
                busy  <= 1'b1;
                cnt   <= CNT_MAX;
                for (int k = 0; k < NCH; k++) begin
                    tgt[k]  <= din[k*DW +: DW];
                    step[k] <= (to_acc(din[k*DW +: DW]) - acc[k]) >>> OSR_LOG2;
                end
            end else if (state == RAMP) begin
                if (cnt == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    for (int k = 0; k < NCH; k++) begin
                        acc[k] <= to_acc(tgt[k]);
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                    for (int k = 0; k < NCH; k++) begin
                        acc[k] <= acc[k] + step[k];
                    end
                end
            end

            if (load && (state == RAMP)) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            assign sample[k] = DW'(sat_signed(64'(signed'(acc[k][AW-1:OSR_LOG2])), DW));

            pdm_sd_mod #(
                .DW (DW)
            ) u_mod (
                .clk    (clk),
                .reset  (reset),
                .sample (sample[k]),
                .pdm    (pdm[k])
            );
        end
    endgenerate

endmodule

`default_nettype wire
